interface_botoes: RTL and testbench
===================================

// Module: interface_botoes
// PURPOSE
// - Front end between the four player buttons and the game control unit.
// - Synchronises and debounces the buttons. Emits a one-cycle jogada pulse
//   with the registered one-hot button code for each valid press.
// - Runs the play-timeout counter that raises timeout while the controller
//   is waiting for a play.
// PARAMETERS
// - DEBOUNCE_CYCLES  50000  cycles an input must be stable (pressed or released) to be accepted; >=2
// - TIMEOUT_CYCLES   5000   counted cycles without a play before timeout asserts; >=2
// PORTS
// - clock            in   1  system clock, rising edge
// - reset            in   1  asynchronous, active-high
// - botoes           in   4  raw button levels, asynchronous, 1 = pressed
// - conta_timeout    in   1  controller is waiting for a play; enables timeout counting
// - zera_timeout     in   1  synchronous clear of timeout counter and timeout flag
// - jogada           out  1  one-cycle pulse: valid press accepted
// - jogada_codigo    out  4  one-hot code of last accepted press; held until next press
// - timeout          out  1  sticky timeout flag
// - db_estado        out  4  current FSM state (debug display)
// BEHAVIOUR
// - Reset values: jogada=0, jogada_codigo=4'b0000, timeout=0, timer=0,
//   debounce counter=0, synchroniser=0, FSM=SEGURA.
// - Synchroniser: 2-FF per bit. The FSM sees botoes_s, 2 cycles after botoes.
// - FSM states and encodings: LIVRE=0, FILTRA=1, PULSO=2, SEGURA=3.
// - LIVRE, botoes_s==0: stay; cnt=0.
// - LIVRE, botoes_s one-hot: cand<=botoes_s, cnt<=0, go FILTRA.
// - LIVRE, botoes_s has >1 bit set: go SEGURA. Chords are ignored and never produce jogada.
// - FILTRA: if botoes_s!=cand, go LIVRE (bounce rejected). Otherwise cnt++.
//   When cnt==DEBOUNCE_CYCLES-1, go PULSO. FILTRA lasts exactly DEBOUNCE_CYCLES cycles.
// - PULSO (1 cycle): jogada=1. jogada_codigo<=cand on entry, so it is valid in the
//   same cycle jogada is high. Then go SEGURA.
// - SEGURA: wait for release. cnt++ while botoes_s==0; cnt<=0 on any nonzero sample.
//   When cnt==DEBOUNCE_CYCLES-1, go LIVRE.
// - Latency: a press clean from edge 0 gives jogada high in cycle 3+DEBOUNCE_CYCLES.
// - One press gives exactly one pulse, however long the button is held.
// - Reset enters SEGURA, so a button held across reset is ignored until released
//   and debounced.
// - Timer priority, per cycle (first match wins):
//   1. zera_timeout: timer<=0, timeout<=0.
//   2. jogada: timer<=0, timeout<=0.
//   3. conta_timeout && !timeout: if timer==TIMEOUT_CYCLES-1 then timeout<=1, timer holds;
//      otherwise timer++.
//   4. Otherwise hold.
// - Timer width: $clog2(TIMEOUT_CYCLES). No wrap; the timer saturates via the sticky flag.
// - timeout first reads 1 in cycle TIMEOUT_CYCLES after counting starts. It stays 1
//   until cleared, including while conta_timeout=0.
// - jogada in the same cycle the timer reaches terminal: jogada wins, timeout stays 0.
// - Debounce counter width: $clog2(DEBOUNCE_CYCLES). Shared by FILTRA and SEGURA;
//   cleared on every state entry.
// - All outputs are registered, except jogada (decoded from state==PULSO) and db_estado.
// STRUCTURE
// - Shared include file: state encoding constants (LIVRE..SEGURA), so the debug display
//   decoder matches db_estado.
// - One sub-module: sincronizador_2ff (WIDTH=4), reset to 0.
// - FSM, debounce counter and timeout counter live in this module.
// TESTING (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20)
// - Reset, hold botoes=0 for 10 cycles, then botoes=4'b0010 for 12 cycles
//   -> one jogada pulse 7 cycles after the rise; jogada_codigo=4'b0010; no further pulse.
// - botoes=4'b0100 toggling every 2 cycles for 16 cycles
//   -> no jogada; db_estado alternates 0/1, never 2.
// - botoes=4'b0101 held, then released, then 4'b1000
//   -> no pulse for the chord; one pulse with jogada_codigo=4'b1000 after release.
// - conta_timeout=1, no press -> timeout=1 from cycle 20 and held;
//   zera_timeout pulse -> timeout=0 next cycle, counting restarts.
// - Button held through reset -> no jogada until release plus 4 clean cycles
//   and a fresh press.
// - conta_timeout=1, press timed so jogada coincides with timer==19
//   -> timeout stays 0 and timer reads 0 afterwards.

Source files
------------

// File: rtl/interface_botoes_pkg.sv
// Shared definitions for the button front end: FSM state encoding and
// small combinational helpers on the four-bit button vector.
package interface_botoes_pkg;

    localparam int NUM_BOTOES = 4;

    // State encoding also drives the debug display through db_estado,
    // so these values are part of the external interface.
    typedef enum logic [1:0] {
        LIVRE  = 2'd0,
        FILTRA = 2'd1,
        PULSO  = 2'd2,
        SEGURA = 2'd3
    } estado_t;

    localparam logic [1:0] ESTADO_LIVRE  = 2'd0;
    localparam logic [1:0] ESTADO_FILTRA = 2'd1;
    localparam logic [1:0] ESTADO_PULSO  = 2'd2;
    localparam logic [1:0] ESTADO_SEGURA = 2'd3;

    // True when exactly one button is pressed.
    function automatic logic eh_one_hot(input logic [NUM_BOTOES-1:0] v);
        logic nao_zero;
        logic um_bit;
        nao_zero = (v != 4'b0000);
        um_bit   = ((v & (v - 4'd1)) == 4'b0000);
        return nao_zero && um_bit;
    endfunction

    // True when no button is pressed.
    function automatic logic eh_livre(input logic [NUM_BOTOES-1:0] v);
        return (v == 4'b0000);
    endfunction

    // Widens the two-bit state into the four-bit debug display code.
    function automatic logic [3:0] codigo_display(input estado_t e);
        return {2'b00, e};
    endfunction

endpackage

// File: rtl/interface_botoes_sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; each bit is
// synchronised independently and both stages clear to zero on reset.
module sincronizador_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dado_i,
    output logic [WIDTH-1:0] dado_o
);

    logic [WIDTH-1:0] estagio1_q;
    logic [WIDTH-1:0] estagio2_q;

    // Two register stages to settle metastability before the FSM sees the level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estagio1_q <= {WIDTH{1'b0}};
            estagio2_q <= {WIDTH{1'b0}};
        end else begin
            estagio1_q <= dado_i;
            estagio2_q <= estagio1_q;
        end
    end

    assign dado_o = estagio2_q;

endmodule

// File: rtl/interface_botoes.sv
// Button front end for the game controller: synchronises and debounces the
// four player buttons, emits one jogada pulse per accepted press with its
// one-hot code, and runs the sticky play-timeout counter.
module interface_botoes
    import interface_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       conta_timeout,
    input  logic       zera_timeout,
    output logic       jogada,
    output logic [3:0] jogada_codigo,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [DB_W-1:0] DB_ULTIMO = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ULTIMO = TO_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]      botoes_s;
    logic            jogada_s;

    estado_t         estado_q;
    logic [DB_W-1:0] cnt_q;
    logic [3:0]      cand_q;
    logic [3:0]      codigo_q;

    logic [TO_W-1:0] timer_q;
    logic [TO_W-1:0] timer_d;
    logic            timeout_q;
    logic            timeout_d;

    sincronizador_2ff #(
        .WIDTH (4)
    ) u_sinc (
        .clock  (clock),
        .reset  (reset),
        .dado_i (botoes),
        .dado_o (botoes_s)
    );

    // Press FSM with shared debounce counter; the counter is cleared on
    // every state entry so FILTRA and SEGURA each start from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Starting in SEGURA ignores any button held across reset.
            estado_q <= SEGURA;
            cnt_q    <= {DB_W{1'b0}};
            cand_q   <= 4'b0000;
            codigo_q <= 4'b0000;
        end else begin
            case (estado_q)
                LIVRE: begin
                    cnt_q <= {DB_W{1'b0}};
                    if (eh_livre(botoes_s)) begin
                        estado_q <= LIVRE;
                    end else if (eh_one_hot(botoes_s)) begin
                        cand_q   <= botoes_s;
                        estado_q <= FILTRA;
                    end else begin
                        // Chords never produce a play; wait for full release.
                        estado_q <= SEGURA;
                    end
                end
                FILTRA: begin
                    if (botoes_s != cand_q) begin
                        estado_q <= LIVRE;
                        cnt_q    <= {DB_W{1'b0}};
                    end else if (cnt_q == DB_ULTIMO) begin
                        // Code is loaded together with the PULSO entry so it
                        // is already valid while jogada is high.
                        estado_q <= PULSO;
                        cnt_q    <= {DB_W{1'b0}};
                        codigo_q <= cand_q;
                    end else begin
                        cnt_q <= cnt_q + {{(DB_W-1){1'b0}}, 1'b1};
                    end
                end
                PULSO: begin
                    estado_q <= SEGURA;
                    cnt_q    <= {DB_W{1'b0}};
                end
                SEGURA: begin
                    if (!eh_livre(botoes_s)) begin
                        cnt_q <= {DB_W{1'b0}};
                    end else if (cnt_q == DB_ULTIMO) begin
                        estado_q <= LIVRE;
                        cnt_q    <= {DB_W{1'b0}};
                    end else begin
                        cnt_q <= cnt_q + {{(DB_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    estado_q <= SEGURA;
                    cnt_q    <= {DB_W{1'b0}};
                end
            endcase
        end
    end

    assign jogada_s = (estado_q == PULSO);

    // Timeout next-state: clear requests beat a play, a play beats counting,
    // and the timer stops at its terminal value once the sticky flag is set.
    always_comb begin
        timer_d   = timer_q;
        timeout_d = timeout_q;
        if (zera_timeout) begin
            timer_d   = {TO_W{1'b0}};
            timeout_d = 1'b0;
        end else if (jogada_s) begin
            timer_d   = {TO_W{1'b0}};
            timeout_d = 1'b0;
        end else if (conta_timeout && !timeout_q) begin
            if (timer_q == TO_ULTIMO) begin
                timeout_d = 1'b1;
            end else begin
                timer_d = timer_q + {{(TO_W-1){1'b0}}, 1'b1};
            end
        end else begin
            timer_d   = timer_q;
            timeout_d = timeout_q;
        end
    end

    // Timeout counter and sticky flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q   <= {TO_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign jogada        = jogada_s;
    assign jogada_codigo = codigo_q;
    assign timeout       = timeout_q;
    assign db_estado     = codigo_display(estado_q);

endmodule

// File: tb/tb_interface_botoes.sv
// Directed bench for interface_botoes with short debounce/timeout settings.
module tb_interface_botoes;

    localparam int DB = 4;
    localparam int TO = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       conta_timeout;
    logic       zera_timeout;
    logic       jogada;
    logic [3:0] jogada_codigo;
    logic       timeout;
    logic [3:0] db_estado;

    int n_cmp = 0;
    int n_bad = 0;

    interface_botoes #(
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .botoes        (botoes),
        .conta_timeout (conta_timeout),
        .zera_timeout  (zera_timeout),
        .jogada        (jogada),
        .jogada_codigo (jogada_codigo),
        .timeout       (timeout),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] b;
        logic       conta;
        logic       zera;
        logic       jog;
        logic [3:0] cod;
        logic       tout;
        logic [3:0] est;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int n, logic [3:0] b, logic c, logic z,
                                logic j, logic [3:0] cod, logic t, logic [3:0] e);
        for (int i = 0; i < n; i++) tbl.push_back('{b, c, z, j, cod, t, e});
    endfunction

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nome, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n, output int pulsos, output logic [3:0] cod);
        pulsos = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (jogada === 1'b1) pulsos++;
        end
        cod = jogada_codigo;
    endtask

    initial begin
        int         p;
        logic [3:0] c;
        int         viu_filtra;

        botoes        = 4'b0000;
        conta_timeout = 1'b0;
        zera_timeout  = 1'b0;
        reset         = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset_jogada", jogada, 1'b0);
        chk("reset_codigo", jogada_codigo, 4'b0000);
        chk("reset_timeout", timeout, 1'b0);
        chk("reset_estado", db_estado, 4'd3);
        reset = 1'b0;

        // Entry i: inputs applied before posedge i, outputs expected after it.
        add(3,  4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd3);
        add(7,  4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0);
        add(2,  4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0);
        add(4,  4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd1);
        add(1,  4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 4'd2);
        add(5,  4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 4'd3);
        add(5,  4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 4'd3);
        add(14, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 4'd0);
        add(1,  4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 4'd0);
        add(3,  4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 4'd0);
        add(1,  4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 4'd0);
        add(19, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 4'd0);
        add(1,  4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 4'd0);
        add(1,  4'b0000, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 4'd0);

        foreach (tbl[i]) begin
            botoes        = tbl[i].b;
            conta_timeout = tbl[i].conta;
            zera_timeout  = tbl[i].zera;
            step();
            if (jogada !== tbl[i].jog) begin
                n_cmp++; n_bad++;
                $display("FAIL tbl_jogada[%0d] got=%0b exp=%0b", i, jogada, tbl[i].jog);
            end else n_cmp++;
            if (jogada_codigo !== tbl[i].cod) begin
                n_cmp++; n_bad++;
                $display("FAIL tbl_codigo[%0d] got=%0b exp=%0b", i, jogada_codigo, tbl[i].cod);
            end else n_cmp++;
            if (timeout !== tbl[i].tout) begin
                n_cmp++; n_bad++;
                $display("FAIL tbl_timeout[%0d] got=%0b exp=%0b", i, timeout, tbl[i].tout);
            end else n_cmp++;
            if (db_estado !== tbl[i].est) begin
                n_cmp++; n_bad++;
                $display("FAIL tbl_estado[%0d] got=%0d exp=%0d", i, db_estado, tbl[i].est);
            end else n_cmp++;
        end

        // Play lands exactly while the timer holds its terminal value.
        zera_timeout  = 1'b0;
        conta_timeout = 1'b1;
        repeat (12) step();
        botoes = 4'b0001;
        repeat (6) step();
        chk("coinc_pre_jogada", jogada, 1'b0);
        step();
        chk("coinc_jogada", jogada, 1'b1);
        chk("coinc_codigo", jogada_codigo, 4'b0001);
        chk("coinc_timeout_durante", timeout, 1'b0);
        step();
        chk("coinc_timeout_apos", timeout, 1'b0);
        chk("coinc_jogada_apos", jogada, 1'b0);
        botoes = 4'b0000;
        repeat (19) step();
        chk("coinc_reinicio_19", timeout, 1'b0);
        step();
        chk("coinc_reinicio_20", timeout, 1'b1);
        conta_timeout = 1'b0;
        zera_timeout  = 1'b1;
        step();
        zera_timeout  = 1'b0;
        chk("coinc_zera", timeout, 1'b0);
        run(8, p, c);

        // Chord is ignored; a clean single press afterwards is accepted.
        botoes = 4'b0101;
        run(8, p, c);
        chk("acorde_pulsos", p, 0);
        chk("acorde_estado", db_estado, 4'd3);
        botoes = 4'b0000;
        run(8, p, c);
        chk("acorde_solto_pulsos", p, 0);
        chk("acorde_solto_estado", db_estado, 4'd0);
        botoes = 4'b1000;
        run(12, p, c);
        chk("apos_acorde_pulsos", p, 1);
        chk("apos_acorde_codigo", c, 4'b1000);
        botoes = 4'b0000;
        run(8, p, c);
        chk("apos_acorde_solto_pulsos", p, 0);

        // Bouncing input never survives the debounce window.
        viu_filtra = 0;
        for (int k = 0; k < 16; k++) begin
            botoes = (((k / 2) % 2) == 0) ? 4'b0100 : 4'b0000;
            step();
            chk("toggle_jogada", jogada, 1'b0);
            chk("toggle_estado_0_1", db_estado[3:1], 3'b000);
            if (db_estado == 4'd1) viu_filtra++;
        end
        chk("toggle_viu_filtra", (viu_filtra > 0), 1'b1);
        chk("toggle_codigo_mantido", jogada_codigo, 4'b1000);

        // Button held through reset is ignored until released and re-pressed.
        botoes = 4'b0001;
        reset  = 1'b1;
        #1;
        chk("reset2_codigo", jogada_codigo, 4'b0000);
        chk("reset2_estado", db_estado, 4'd3);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        run(15, p, c);
        chk("segura_reset_pulsos", p, 0);
        chk("segura_reset_estado", db_estado, 4'd3);
        botoes = 4'b0000;
        run(10, p, c);
        chk("segura_solto_pulsos", p, 0);
        chk("segura_solto_estado", db_estado, 4'd0);
        botoes = 4'b0001;
        run(12, p, c);
        chk("nova_press_pulsos", p, 1);
        chk("nova_press_codigo", c, 4'b0001);
        botoes = 4'b0000;
        run(8, p, c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
